// File: rtl/carry_chain_pkg.sv
// Shared types, sizing helpers and configuration check for the carry-chain sequencer.
package carry_chain_pkg;

  localparam int unsigned TOTAL_W_DEF = 32;
  localparam int unsigned CHAIN_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of segment passes needed to cover the full operand width.
  function automatic int unsigned calc_nchunk(input int unsigned tw, input int unsigned cw);
    return tw / cw;
  endfunction

  // Chunk-index width; never below one bit.
  function automatic int unsigned calc_idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Operand width must split evenly into at least two segment passes.
  function automatic bit cfg_ok(input int unsigned tw, input int unsigned cw);
    return (cw != 0) && ((tw % cw) == 0) && ((tw / cw) >= 2);
  endfunction

  localparam int unsigned NCHUNK = calc_nchunk(TOTAL_W_DEF, CHAIN_W_DEF);
  localparam int unsigned IDX_W  = calc_idx_w(NCHUNK);
  localparam bit          CFG_OK = cfg_ok(TOTAL_W_DEF, CHAIN_W_DEF);

endpackage

// File: rtl/carry_chain_seg.sv
// Propagate/generate ripple carry-chain segment shared by the sequencer.
module carry_chain_seg #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_p,
  input  logic [W-1:0] i_g,
  input  logic         i_ci,
  output logic [W-1:0] o_sum,
  output logic         o_co
);

  logic [W:0] w_c;

  // Ripple the carry cell by cell: SUM = CI ^ P, CO = P ? CI : G.
  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_ci;
    for (int i = 0; i < int'(W); i++) begin
      o_sum[i]  = w_c[i] ^ i_p[i];
      w_c[i+1]  = i_p[i] ? w_c[i] : i_g[i];
    end
  end

  assign o_co = w_c[W];

endmodule

// File: rtl/carry_chain_seq_ctrl.sv
// Multi-cycle wide add/subtract sequencer driving one shared carry-chain segment.
module carry_chain_seq_ctrl
  import carry_chain_pkg::*;
#(
  parameter int unsigned TOTAL_W = 32,
  parameter int unsigned CHAIN_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TOTAL_W-1:0] in_a,
  input  logic [TOTAL_W-1:0] in_b,
  input  logic               in_sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TOTAL_W-1:0] out_sum,
  output logic               out_cout,
  output logic               out_ovf,
  output logic [CHAIN_W-1:0] chain_p,
  output logic [CHAIN_W-1:0] chain_g,
  output logic               chain_ci,
  input  logic [CHAIN_W-1:0] chain_sum,
  input  logic               chain_co
);

  localparam int unsigned N_CHUNK = calc_nchunk(TOTAL_W, CHAIN_W);
  localparam int unsigned CIDX_W  = calc_idx_w(N_CHUNK);
  localparam int unsigned REM_W   = TOTAL_W - CHAIN_W;

  if (!cfg_ok(TOTAL_W, CHAIN_W)) begin : g_cfg_bad
    $error("carry_chain_seq_ctrl: TOTAL_W must be a multiple of CHAIN_W with at least two chunks");
  end

  state_e              r_state;
  logic [REM_W-1:0]    r_a;        // chunks still to be presented, next one at the bottom
  logic [REM_W-1:0]    r_b;
  logic [REM_W-1:0]    r_sum;      // chunks already summed, newest at the top
  logic                r_a_msb;
  logic                r_b_msb;
  logic [CIDX_W-1:0]   r_idx;

  logic [TOTAL_W-1:0]  w_bx;
  logic [TOTAL_W-1:0]  w_sum_full;
  logic                w_accept;
  logic                w_last;

  // New operands are taken when idle, or when a finished result leaves this cycle.
  assign in_ready   = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_bx       = in_b ^ {TOTAL_W{in_sub}};
  assign w_last     = (r_idx == CIDX_W'(N_CHUNK - 1));
  assign w_sum_full = {chain_sum, r_sum};

  // Sequencer: segment inputs are registered one cycle ahead so the segment
  // sees chunk k (and chain_ci acts as the inter-chunk carry register) during RUN cycle k.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_a_msb   <= 1'b0;
      r_b_msb   <= 1'b0;
      r_idx     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      chain_p   <= '0;
      chain_g   <= '0;
      chain_ci  <= 1'b0;
    end else if (w_accept) begin
      r_state   <= RUN;
      r_a       <= in_a[TOTAL_W-1:CHAIN_W];
      r_b       <= w_bx[TOTAL_W-1:CHAIN_W];
      r_sum     <= '0;
      r_a_msb   <= in_a[TOTAL_W-1];
      r_b_msb   <= w_bx[TOTAL_W-1];
      r_idx     <= '0;
      out_valid <= 1'b0;
      chain_p   <= in_a[CHAIN_W-1:0] ^ w_bx[CHAIN_W-1:0];
      chain_g   <= in_a[CHAIN_W-1:0] & w_bx[CHAIN_W-1:0];
      chain_ci  <= in_sub;
    end else begin
      case (r_state)
        RUN: begin
          r_sum <= w_sum_full[TOTAL_W-1:CHAIN_W];
          if (w_last) begin
            r_state   <= DONE;
            out_valid <= 1'b1;
            out_sum   <= w_sum_full;
            out_cout  <= chain_co;
            out_ovf   <= (r_a_msb == r_b_msb) && (chain_sum[CHAIN_W-1] != r_a_msb);
            chain_p   <= '0;
            chain_g   <= '0;
            chain_ci  <= 1'b0;
          end else begin
            r_idx    <= r_idx + CIDX_W'(1);
            r_a      <= r_a >> CHAIN_W;
            r_b      <= r_b >> CHAIN_W;
            chain_p  <= r_a[CHAIN_W-1:0] ^ r_b[CHAIN_W-1:0];
            chain_g  <= r_a[CHAIN_W-1:0] & r_b[CHAIN_W-1:0];
            chain_ci <= chain_co;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state   <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_carry_chain_seq_ctrl.sv
// Self-checking bench for carry_chain_seq_ctrl with the segment model attached.
module tb_carry_chain_seq_ctrl;

  localparam int unsigned TW = 32;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic [TW-1:0] sum;
    logic          cout;
    logic          ovf;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_a;
  logic [TW-1:0] in_b;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic [CW-1:0] chain_p;
  logic [CW-1:0] chain_g;
  logic          chain_ci;
  logic [CW-1:0] chain_sum;
  logic          chain_co;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  carry_chain_seq_ctrl #(.TOTAL_W(TW), .CHAIN_W(CW)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .chain_p   (chain_p),
    .chain_g   (chain_g),
    .chain_ci  (chain_ci),
    .chain_sum (chain_sum),
    .chain_co  (chain_co)
  );

  carry_chain_seg #(.W(CW)) u_seg (
    .i_p   (chain_p),
    .i_g   (chain_g),
    .i_ci  (chain_ci),
    .o_sum (chain_sum),
    .o_co  (chain_co)
  );

  // Reference result from plain wide arithmetic.
  function automatic exp_t model(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic sub);
    logic [TW-1:0] bx;
    logic [TW:0]   r;
    exp_t          e;
    bx     = sub ? ~b : b;
    r      = {1'b0, a} + {1'b0, bx} + (TW+1)'(sub);
    e.sum  = r[TW-1:0];
    e.cout = r[TW];
    e.ovf  = (a[TW-1] == bx[TW-1]) && (r[TW-1] != a[TW-1]);
    return e;
  endfunction

  // Present one operand pair, push its expectation, return at the first RUN-cycle negedge.
  task automatic send_op(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic sub,
                         output bit timeout);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    timeout = !in_ready;
    if (!timeout) sb_q.push_back(model(a, b, sub));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_sub   = 1'($urandom_range(0, 1));
  endtask

  // Count edges from the accept edge until out_valid, bounded.
  task automatic wait_valid(output int lat, output bit timeout);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    timeout = !out_valid;
  endtask

  // Let the sink take the current result.
  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({out_valid, out_sum, out_cout, out_ovf} !== {1'b0, TW'(0), 1'b0, 1'b0})
      $display("FAIL reset_outputs: got valid=%0b sum=%h cout=%0b ovf=%0b want 0/0/0/0",
               out_valid, out_sum, out_cout, out_ovf);
    else n_pass++;
    n_checks++;
    if ({chain_p, chain_g, chain_ci} !== {CW'(0), CW'(0), 1'b0})
      $display("FAIL reset_chain: got p=%h g=%h ci=%0b want 0/0/0", chain_p, chain_g, chain_ci);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_add_carry_ripple();
    bit   to;
    exp_t e;
    send_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, to);
    n_checks++;
    if (to) $display("FAIL ripple_accept: got in_ready=0 want 1");
    else n_pass++;
    n_checks++;
    if ({chain_p, chain_g} !== {8'hFE, 8'h01})
      $display("FAIL ripple_pg0: got p=%h g=%h want fe/01", chain_p, chain_g);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (chain_ci !== ((k == 0) ? 1'b0 : 1'b1) || out_valid !== 1'b0 || in_ready !== 1'b0)
        $display("FAIL ripple_run_c%0d: got ci=%0b valid=%0b in_ready=%0b want ci=%0b valid=0 in_ready=0",
                 k + 1, chain_ci, out_valid, in_ready, (k == 0) ? 1'b0 : 1'b1);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if (out_valid !== 1'b1 || chain_ci !== 1'b0 || chain_p !== 8'h00)
      $display("FAIL ripple_latency: got valid=%0b ci=%0b p=%h at edge 4 want 1/0/00",
               out_valid, chain_ci, chain_p);
    else n_pass++;
    n_checks++;
    if (sb_q.size() == 0) $display("FAIL ripple_result: got empty scoreboard want 1 entry");
    else begin
      e = sb_q.pop_front();
      if ({out_sum, out_cout, out_ovf} !== {e.sum, e.cout, e.ovf})
        $display("FAIL ripple_result: got %h/%0b/%0b want %h/%0b/%0b",
                 out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
      else n_pass++;
    end
    release_result();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL ripple_to_idle: got valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_arith_table();
    logic [TW-1:0] ta [4] = '{32'h7FFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'hDEAD_BEEF};
    logic [TW-1:0] tb [4] = '{32'h0000_0001, 32'h0000_0007, 32'h0000_0001, 32'h1234_5678};
    logic          ts [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    exp_t          fixed [3] = '{{32'h8000_0000, 1'b0, 1'b1},
                                 {32'hFFFF_FFFE, 1'b0, 1'b0},
                                 {32'h7FFF_FFFF, 1'b1, 1'b1}};
    bit            to;
    int            lat;
    exp_t          e;
    for (int i = 0; i < 4; i++) begin
      send_op(ta[i], tb[i], ts[i], to);
      wait_valid(lat, to);
      n_checks++;
      if (to || lat != 4) $display("FAIL arith%0d_latency: got %0d edges want 4", i, lat);
      else n_pass++;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if ({out_sum, out_cout, out_ovf} !== {e.sum, e.cout, e.ovf})
          $display("FAIL arith%0d_result: got %h/%0b/%0b want %h/%0b/%0b",
                   i, out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
        else n_pass++;
        if (i < 3) begin
          n_checks++;
          if ({out_sum, out_cout, out_ovf} !== {fixed[i].sum, fixed[i].cout, fixed[i].ovf})
            $display("FAIL arith%0d_vector: got %h/%0b/%0b want %h/%0b/%0b", i,
                     out_sum, out_cout, out_ovf, fixed[i].sum, fixed[i].cout, fixed[i].ovf);
          else n_pass++;
        end
      end
      release_result();
    end
  endtask

  task automatic test_back_to_back();
    bit            to;
    int            lat;
    exp_t          e;
    logic [TW-1:0] held;
    send_op(32'h0000_0005, 32'h0000_0009, 1'b0, to);
    wait_valid(lat, to);
    held     = out_sum;
    in_valid = 1'b1;
    in_a     = 32'h0000_0001;
    in_b     = 32'h0000_0002;
    in_sub   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== 32'h0000_000E || in_ready !== 1'b0)
        $display("FAIL stall_c%0d: got valid=%0b sum=%h in_ready=%0b want 1/0000000e/0",
                 k, out_valid, out_sum, in_ready);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if (out_sum !== held) $display("FAIL stall_hold: got %h want %h", out_sum, held);
    else n_pass++;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %0b want 1", in_ready);
    else n_pass++;
    if (sb_q.size() != 0) e = sb_q.pop_front();
    sb_q.push_back(model(32'h0000_0001, 32'h0000_0002, 1'b0));
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || chain_p !== 8'h03)
      $display("FAIL b2b_same_cycle: got valid=%0b p=%h want 0/03", out_valid, chain_p);
    else n_pass++;
    wait_valid(lat, to);
    n_checks++;
    if (to || lat != 4) $display("FAIL b2b_latency: got %0d edges want 4", lat);
    else n_pass++;
    n_checks++;
    if (sb_q.size() == 0) $display("FAIL b2b_result: got empty scoreboard want 1 entry");
    else begin
      e = sb_q.pop_front();
      if (out_sum !== 32'h0000_0003 || {out_sum, out_cout, out_ovf} !== {e.sum, e.cout, e.ovf})
        $display("FAIL b2b_result: got %h/%0b/%0b want %h/%0b/%0b",
                 out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
      else n_pass++;
    end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    bit   to;
    int   lat;
    int   stray;
    exp_t e;
    send_op(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0, to);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    if (sb_q.size() != 0) void'(sb_q.pop_back());
    n_checks++;
    if ({out_valid, chain_p, chain_g, chain_ci, in_ready} !== {1'b0, CW'(0), CW'(0), 1'b0, 1'b1})
      $display("FAIL midrun_reset: got valid=%0b p=%h g=%h ci=%0b in_ready=%0b want 0/00/00/0/1",
               out_valid, chain_p, chain_g, chain_ci, in_ready);
    else n_pass++;
    stray = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid !== 1'b0) stray++;
      @(negedge clk);
    end
    n_checks++;
    if (stray != 0) $display("FAIL midrun_no_result: got %0d valid cycles want 0", stray);
    else n_pass++;
    send_op(32'h0000_0010, 32'h0000_0020, 1'b0, to);
    wait_valid(lat, to);
    n_checks++;
    if (to || sb_q.size() == 0) $display("FAIL midrun_followup: got timeout=%0b want result", to);
    else begin
      e = sb_q.pop_front();
      if (out_sum !== 32'h0000_0030 || {out_sum, out_cout, out_ovf} !== {e.sum, e.cout, e.ovf})
        $display("FAIL midrun_followup: got %h/%0b/%0b want %h/%0b/%0b",
                 out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
      else n_pass++;
    end
    release_result();
  endtask

  task automatic test_random();
    bit   to;
    int   lat;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      send_op($urandom, $urandom, 1'($urandom_range(0, 1)), to);
      wait_valid(lat, to);
      n_checks++;
      if (to || lat != 4 || sb_q.size() == 0)
        $display("FAIL rand%0d_latency: got %0d edges want 4", i, lat);
      else begin
        e = sb_q.pop_front();
        if ({out_sum, out_cout, out_ovf} !== {e.sum, e.cout, e.ovf})
          $display("FAIL rand%0d_result: got %h/%0b/%0b want %h/%0b/%0b",
                   i, out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
        else n_pass++;
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_add_carry_ripple();
    test_arith_table();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/carry_chain_seq_ctrl.md
Name: carry_chain_seq_ctrl

Overview:
Multi-cycle wide add/subtract sequencer. It time-shares one CHAIN_W-bit propagate/generate carry-chain segment across a TOTAL_W-bit operation, one chunk per cycle. It registers the carry between chunks. It sits between a valid/ready operand source and result sink, and drives the chain segment's P/G/CI inputs while reading back SUM/CO.

Parameters:
- TOTAL_W, 32, operand/result width; must be a multiple of CHAIN_W.
- CHAIN_W, 8, width of the shared carry-chain segment; TOTAL_W/CHAIN_W >= 2.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  operand accept.
- in_a  input  TOTAL_W  operand A.
- in_b  input  TOTAL_W  operand B.
- in_sub  input  1  1 = A-B, 0 = A+B.
- out_valid  output  1  result valid.
- out_ready  input  1  result accept.
- out_sum  output  TOTAL_W  result.
- out_cout  output  1  final carry out (for sub: 1 = no borrow).
- out_ovf  output  1  signed overflow.
- chain_p  output  CHAIN_W  propagate to segment.
- chain_g  output  CHAIN_W  generate to segment.
- chain_ci  output  1  carry-in to segment bit 0.
- chain_sum  input  CHAIN_W  segment sum, combinational from chain_p/chain_ci.
- chain_co  input  1  segment carry-out.

Behaviour:
- Reset is synchronous and active-high; clock is clk, reset is reset. Reset state:
  - FSM = IDLE.
  - out_valid=0, out_sum=0, out_cout=0, out_ovf=0.
  - chain_p=0, chain_g=0, chain_ci=0.
  - chunk index=0, carry reg=0.
- FSM states: IDLE, RUN, DONE. NCHUNK = TOTAL_W/CHAIN_W.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept occurs on in_valid && in_ready. On accept:
  - Latch A and B' = in_b ^ {TOTAL_W{in_sub}}.
  - carry reg <= in_sub; idx <= 0; state <= RUN.
- RUN, each cycle with chunk k = idx:
  - chain_p = A[k] ^ B'[k], chain_g = A[k] & B'[k], chain_ci = carry reg.
  - Capture chain_sum into sum[k]; carry reg <= chain_co; idx++.
  - When k == NCHUNK-1, state <= DONE instead of incrementing.
- Outside RUN, chain_p/chain_g/chain_ci are forced to 0 to suppress toggling on the shared segment.
- DONE:
  - out_valid=1.
  - out_sum = assembled sum; out_cout = last chain_co.
  - out_ovf = (A_msb == B'_msb) && (sum_msb != A_msb).
  - Outputs are stable while out_ready=0.
- Handshake out_valid && out_ready:
  - If in_valid is also 1, accept the new operands in the same cycle and go directly to RUN.
  - Otherwise go to IDLE and clear out_valid.
- Latency: out_valid rises exactly NCHUNK cycles after the accept edge (4 cycles for the defaults). Throughput is one result per NCHUNK+1 cycles when the sink never stalls.
- Simultaneous reset with any handshake: reset wins. The operation is discarded and no out_valid is produced.
- Reset mid-RUN: return to IDLE next edge with all reset values; the partial sum is lost.
- Inputs are ignored while in RUN; in_a/in_b need not be held after accept.

Decomposition:
- Shared package carry_chain_pkg holds:
  - The FSM state enum (IDLE/RUN/DONE).
  - Localparam NCHUNK.
  - Chunk-index width $clog2(NCHUNK).
  - An elaboration check that TOTAL_W % CHAIN_W == 0.
- One sub-module, carry_chain_seg (CHAIN_W cells, each SUM = CI^P, CO = P ? CI : G, rippled). It is instantiated outside this block next to it. The bench uses it as the segment model.

Test Plan:
(Defaults TOTAL_W=32, CHAIN_W=8.)
1. Add 0xFFFFFFFF + 0x00000001 -> out_sum=0x00000000, cout=1, ovf=0; out_valid rises 4 cycles after accept; chain_ci is 1 in each of RUN cycles 2–4.
2. Add 0x7FFFFFFF + 0x00000001 -> out_sum=0x80000000, cout=0, ovf=1.
3. Sub 0x00000005 - 0x00000007 -> out_sum=0xFFFFFFFE, cout=0, ovf=0.
4. Sub 0x80000000 - 0x00000001 -> out_sum=0x7FFFFFFF, cout=1, ovf=1.
5. Backpressure and back-to-back:
   - Hold out_ready=0 for 3 cycles in DONE -> out_sum/out_valid stable, in_ready=0.
   - Raise out_ready with in_valid=1 (0x1+0x2) -> same-cycle accept, next result 0x00000003 with out_valid 4 cycles later.
6. Assert reset during the 3rd RUN cycle -> next cycle state IDLE, out_valid=0, chain_p/chain_g/chain_ci=0, in_ready=1. The following operation 0x10+0x20 gives 0x00000030.
